// File: rtl/gcd_pkg.sv
`default_nettype none
// ============================================================================
// Module      : gcd_pkg
// Description : Shared types and helpers for the streaming GCD engine.
// Revision    : 1.0 - initial release
// ============================================================================
package gcd_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        HOLD = 2'd2
    } state_e;

    // One extra pointer bit distinguishes a full FIFO from an empty one.
    function automatic int ptr_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/gcd_result_fifo.sv
`default_nettype none
// ============================================================================
// Module      : gcd_result_fifo
// Description : Circular result buffer; head reads zero while empty.
// Revision    : 1.0 - initial release
// ============================================================================
module gcd_result_fifo
    import gcd_pkg::*;
#(
    parameter int DATA_W = 36,
    parameter int DEPTH  = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    output logic              full,
    input  logic              pop,
    output logic [DATA_W-1:0] head,
    output logic              empty
);

    localparam int c_PTR_W = ptr_width(DEPTH);
    localparam int c_IDX_W = c_PTR_W - 1;

    logic [DATA_W-1:0]  r_mem [DEPTH];
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic               w_do_push;
    logic               w_do_pop;

    assign empty = (r_wr_ptr == r_rd_ptr);
    assign full  = (r_wr_ptr[c_PTR_W-1] != r_rd_ptr[c_PTR_W-1]) &&
                   (r_wr_ptr[c_IDX_W-1:0] == r_rd_ptr[c_IDX_W-1:0]);

    assign w_do_pop  = pop && !empty;
    // A pop in the same cycle frees the slot a full buffer needs.
    assign w_do_push = push && (!full || w_do_pop);

    assign head = empty ? '0 : r_mem[r_rd_ptr[c_IDX_W-1:0]];

    always_ff @(posedge clock) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (w_do_push) r_mem[r_wr_ptr[c_IDX_W-1:0]] <= push_data;
    end

endmodule
`default_nettype wire

// File: rtl/gcd_stream.sv
`default_nettype none
// ============================================================================
// Module      : gcd_stream
// Description : Subtractive GCD engine with tagged, FIFO-buffered results.
// Revision    : 1.0 - initial release
// ============================================================================
module gcd_stream
    import gcd_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int TAG_W = 4,
    parameter int DEPTH = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out,
    output logic [TAG_W-1:0] out_tag,
    output logic             busy
);

    typedef struct packed {
        logic [WIDTH-1:0] data;
        logic [TAG_W-1:0] tag;
    } result_t;

    state_e           r_state;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [TAG_W-1:0] r_tag;
    logic [WIDTH-1:0] r_res;
    logic             r_in_ready;
    logic             r_busy;

    logic             w_done;
    logic [WIDTH-1:0] w_r;
    logic             w_full;
    logic             w_empty;
    logic             w_pop;
    logic             w_can_push;
    logic             w_push;
    result_t          w_push_data;
    result_t          w_head;

    assign w_done     = (r_a == '0) || (r_b == '0) || (r_a == r_b);
    assign w_r        = (r_a == '0) ? r_b : r_a;
    assign w_pop      = !w_empty && out_ready;
    assign w_can_push = !w_full || w_pop;
    assign w_push     = w_can_push &&
                        (((r_state == CALC) && w_done) || (r_state == HOLD));

    always_comb begin
        w_push_data.data = (r_state == HOLD) ? r_res : w_r;
        w_push_data.tag  = r_tag;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state    <= IDLE;
            r_a        <= '0;
            r_b        <= '0;
            r_tag      <= '0;
            r_res      <= '0;
            r_in_ready <= 1'b1;
            r_busy     <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_a        <= x;
                        r_b        <= y;
                        r_tag      <= in_tag;
                        r_state    <= CALC;
                        r_in_ready <= 1'b0;
                        r_busy     <= 1'b1;
                    end
                end
                CALC: begin
                    if (w_done) begin
                        if (w_can_push) begin
                            r_state    <= IDLE;
                            r_in_ready <= 1'b1;
                            r_busy     <= 1'b0;
                        end else begin
                            r_res   <= w_r;
                            r_state <= HOLD;
                        end
                    end else if (r_a > r_b) begin
                        r_a <= r_a - r_b;
                    end else begin
                        r_b <= r_b - r_a;
                    end
                end
                HOLD: begin
                    if (w_can_push) begin
                        r_state    <= IDLE;
                        r_in_ready <= 1'b1;
                        r_busy     <= 1'b0;
                    end
                end
                default: begin
                    r_state    <= IDLE;
                    r_in_ready <= 1'b1;
                    r_busy     <= 1'b0;
                end
            endcase
        end
    end

    gcd_result_fifo #(
        .DATA_W ($bits(result_t)),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (w_push),
        .push_data (w_push_data),
        .full      (w_full),
        .pop       (w_pop),
        .head      (w_head),
        .empty     (w_empty)
    );

    assign in_ready  = r_in_ready;
    assign busy      = r_busy;
    assign out_valid = !w_empty;
    assign out       = w_head.data;
    assign out_tag   = w_head.tag;

endmodule
`default_nettype wire
